// File: rtl/udiv16_8_if.sv
// Handshake/result bundle for the udiv16_8 sequential divider.
//   start     : request pulse, honoured only while the divider is not busy
//   dividend  : N-bit unsigned dividend, sampled on the accepting edge
//   divisor   : D-bit unsigned divisor, sampled on the accepting edge
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   quotient  : N-bit quotient of the last completed operation
//   remainder : D-bit remainder of the last completed operation
//   dbz       : last completed operation had a zero divisor
interface udiv16_8_if #(
    parameter int unsigned N = 16,
    parameter int unsigned D = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [D-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [D-1:0] remainder;
    logic         dbz;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/udiv16_8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Companion to the 8x8 MPY8 multiplier.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : udiv16_8_if slave modport (start/dividend/divisor in,
//         busy/done/quotient/remainder/dbz out, all outputs registered)
// Latency is fixed: start accepted at edge t0, done visible after t0+N.
// N must be >= D.
module udiv16_8 #(
    parameter int unsigned N = 16,
    parameter int unsigned D = 8
) (
    input  logic          clk,
    input  logic          rst,
    udiv16_8_if.slave     bus
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  rem_q, rem_d;     // partial remainder (always < divisor when divisor != 0)
    logic [N-1:0]  dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [D-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [D-1:0]  rmd_q, rmd_d;
    logic          dbz_q, dbz_d;

    // D+1-bit shifted partial remainder and its trial subtraction; the
    // extra top bit of trial is the borrow.
    logic [D:0]    rem_shift;
    logic [D+1:0]  trial;

    assign rem_shift = {rem_q, dvd_q[N-1]};
    assign trial     = {1'b0, rem_shift} - {2'b00, dvs_q};

    // Next-state and datapath.
    // With a zero divisor the trial never borrows, so the quotient fills
    // with ones and the remainder ends up holding dividend[D-1:0], which is
    // exactly the required divide-by-zero result.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (trial[D+1]) begin
                    rem_d = rem_shift[D-1:0];
                    dvd_d = {dvd_q[N-2:0], 1'b0};
                end else begin
                    rem_d = trial[D-1:0];
                    dvd_d = {dvd_q[N-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = dvd_d;
                    rmd_d   = rem_d;
                    dbz_d   = (dvs_q == '0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_udiv16_8.sv
// Self-checking bench for udiv16_8: directed vector table, handshake and
// reset corner sequences, and a random sweep against / and %.
module tb_udiv16_8;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    udiv16_8_if #(.N(16), .D(8)) bus ();

    udiv16_8 #(.N(16), .D(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive a start pulse at the next negedge; returns after the accepting edge (+1).
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
    endtask

    // Wait for done; cyc counts edges from the accepting edge (which is 1).
    task automatic wait_done(input int start_cyc, output int cyc);
        cyc = start_cyc;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int cyc);
        issue(a, b);
        wait_done(1, cyc);
    endtask

    initial begin
        int cyc;
        int ea, eb, eq, er;
        int aq, ar;
        string nm;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{16'd200,   8'd7,   16'd28,    8'd4,    1'b0};
        vecs[1]  = '{16'd65535, 8'd255, 16'd257,   8'd0,    1'b0};
        vecs[2]  = '{16'd1234,  8'd1,   16'd1234,  8'd0,    1'b0};
        vecs[3]  = '{16'd300,   8'd0,   16'hFFFF,  8'h2C,   1'b0 | 1'b1};
        vecs[4]  = '{16'd0,     8'd9,   16'd0,     8'd0,    1'b0};
        vecs[5]  = '{16'd255,   8'd16,  16'd15,    8'd15,   1'b0};
        vecs[6]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0};
        vecs[7]  = '{16'd12,    8'd13,  16'd0,     8'd12,   1'b0};
        vecs[8]  = '{16'd0,     8'd0,   16'hFFFF,  8'd0,    1'b1};
        vecs[9]  = '{16'd1000,  8'd3,   16'd333,   8'd1,    1'b0};
        vecs[10] = '{16'd40000, 8'd13,  16'd3076,  8'd12,   1'b0};
        vecs[11] = '{16'hABCD,  8'd0,   16'hFFFF,  8'hCD,   1'b1};

        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 16'd500;
        bus.divisor  = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  32'(bus.busy), 32'd0);
        check("reset_done",  32'(bus.done), 32'd0);
        check("reset_quo",   32'(bus.quotient), 32'd0);
        check("reset_rem",   32'(bus.remainder), 32'd0);
        check("reset_dbz",   32'(bus.dbz), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, cyc);
            nm = $sformatf("vec%0d", i);
            check({nm, "_quo"},  32'(bus.quotient),  32'(vecs[i].q));
            check({nm, "_rem"},  32'(bus.remainder), 32'(vecs[i].r));
            check({nm, "_dbz"},  32'(bus.dbz),       32'(vecs[i].z));
            check({nm, "_lat"},  32'(cyc),           32'd17);
            check({nm, "_busy_in_done"}, 32'(bus.busy), 32'd0);
            @(posedge clk);
            #1;
            check({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
            check({nm, "_hold_quo"},   32'(bus.quotient), 32'(vecs[i].q));
        end

        // start while busy is ignored.
        issue(16'd1000, 8'd3);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 8'd5;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'hFFFF;
        bus.divisor  = 8'd2;
        check("busy_ignore_busy", 32'(bus.busy), 32'd1);
        wait_done(5, cyc);
        check("busy_ignore_quo", 32'(bus.quotient),  32'd333);
        check("busy_ignore_rem", 32'(bus.remainder), 32'd1);
        check("busy_ignore_lat", 32'(cyc), 32'd17);

        // Back-to-back: start during the done cycle.
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 8'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_done_low", 32'(bus.done), 32'd0);
        check("b2b_busy",     32'(bus.busy), 32'd1);
        check("b2b_hold_quo", 32'(bus.quotient), 32'd333);
        wait_done(0, cyc);
        check("b2b_quo", 32'(bus.quotient),  32'd10);
        check("b2b_rem", 32'(bus.remainder), 32'd0);
        check("b2b_lat", 32'(cyc), 32'd16);
        @(posedge clk);
        #1;

        // Reset mid-operation.
        issue(16'd40000, 8'd13);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_quo",  32'(bus.quotient), 32'd0);
        check("midrst_rem",  32'(bus.remainder), 32'd0);
        check("midrst_dbz",  32'(bus.dbz), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(bus.done), 32'd0);
        run_op(16'd40000, 8'd13, cyc);
        check("after_rst_quo", 32'(bus.quotient),  32'd3076);
        check("after_rst_rem", 32'(bus.remainder), 32'd12);
        check("after_rst_lat", 32'(cyc), 32'd17);

        // Random sweep.
        for (int i = 0; i < 200; i++) begin
            ea = int'($urandom_range(0, 65535));
            eb = int'($urandom_range(1, 255));
            eq = ea / eb;
            er = ea % eb;
            run_op(16'(ea), 8'(eb), cyc);
            aq = int'(bus.quotient);
            ar = int'(bus.remainder);
            check($sformatf("rnd%0d_quo(%0d/%0d)", i, ea, eb), 32'(bus.quotient),  32'(eq));
            check($sformatf("rnd%0d_rem(%0d/%0d)", i, ea, eb), 32'(bus.remainder), 32'(er));
            check($sformatf("rnd%0d_inv", i), 32'(aq * eb + ar), 32'(ea));
            check($sformatf("rnd%0d_rlt", i), 32'(ar < eb), 32'd1);
            check($sformatf("rnd%0d_dbz", i), 32'(bus.dbz), 32'd0);
            check($sformatf("rnd%0d_lat", i), 32'(cyc), 32'd17);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
